sbox_array: RTL and testbench

- Parametrised, pipelined multi-lane AES byte-substitution unit with valid/ready handshake.
- Applies the FIPS-197 forward S-box or inverse S-box to LANES bytes in parallel; the mode is selected per transfer.
- Successor to the single-byte combinational S-box. Feeds SubBytes (LANES=16), SubWord key expansion (LANES=4) and the decrypt datapath (inverse mode) of the AES-256/GCM core.

---
 rtl/sbox_array_if.sv | 26 ++
 rtl/sbox_array.sv | 98 +++++++++
 tb/tb_sbox_array.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbox_array_if.sv
// Valid/ready stream bundle for the multi-lane S-box unit: one input beat side,
// one result side, both carrying LANES bytes plus a sideband tag.
interface sbox_array_if #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic                 in_inv;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic [TAG_W-1:0]     out_tag;

  modport slave (
    input  in_valid, in_data, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/sbox_array.sv
// Two-stage pipelined AES forward/inverse S-box over LANES independent bytes,
// with a per-beat mode bit and a sideband tag that travel with the data.
module sbox_array #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  sbox_array_if.slave bus
);

  localparam int DATA_W = 8 * LANES;

  localparam logic [0:255][7:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    return inv ? INV_TBL[b] : FWD_TBL[b];
  endfunction

  logic              vld_p1;
  logic              inv_p1;
  logic [DATA_W-1:0] data_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic              vld_p2;
  logic [DATA_W-1:0] data_p2;
  logic [TAG_W-1:0]  tag_p2;
  logic              adv_p1;
  logic              adv_p2;
  logic [DATA_W-1:0] lookup_p1;

  // A stage advances when it is empty or the stage after it is draining; in_ready
  // therefore depends only on out_ready and the stage valids.
  assign adv_p2       = !vld_p2 || bus.out_ready;
  assign adv_p1       = !vld_p1 || adv_p2;
  assign bus.in_ready = adv_p1;

  always_comb begin
    lookup_p1 = '0;
    for (int i = 0; i < LANES; i++) begin
      lookup_p1[8*i +: 8] = sub_byte(data_p1[8*i +: 8], inv_p1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      inv_p1  <= 1'b0;
      data_p1 <= '0;
      tag_p1  <= '0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      tag_p2  <= '0;
    end else begin
      // p1: capture the input beat
      if (adv_p1) begin
        vld_p1 <= bus.in_valid;
        if (bus.in_valid) begin
          data_p1 <= bus.in_data;
          inv_p1  <= bus.in_inv;
          tag_p1  <= bus.in_tag;
        end
      end
      // p2: register the table lookup; these registers drive the result side
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          data_p2 <= lookup_p1;
          tag_p2  <= tag_p1;
        end
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_data  = data_p2;
  assign bus.out_tag   = tag_p2;

endmodule

// File: tb/tb_sbox_array.sv
// Directed bench for sbox_array: three instances (4/4, 1/1, 16/8 lanes/tag bits)
// driven in lockstep from one stimulus set, checked against a GF(2^8) S-box model.
module tb_sbox_array;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_inv;
  logic         out_ready;
  logic [127:0] in_data;
  logic [7:0]   in_tag;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];

  typedef struct {
    logic [127:0] d;
    logic         inv;
    logic [7:0]   tag;
    int           acc;
  } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  sbox_array_if #(.LANES(4),  .TAG_W(4)) b4 ();
  sbox_array_if #(.LANES(1),  .TAG_W(1)) b1 ();
  sbox_array_if #(.LANES(16), .TAG_W(8)) b16 ();

  assign b4.in_valid   = in_valid;
  assign b4.in_data    = in_data[31:0];
  assign b4.in_inv     = in_inv;
  assign b4.in_tag     = in_tag[3:0];
  assign b4.out_ready  = out_ready;
  assign b1.in_valid   = in_valid;
  assign b1.in_data    = in_data[7:0];
  assign b1.in_inv     = in_inv;
  assign b1.in_tag     = in_tag[0];
  assign b1.out_ready  = out_ready;
  assign b16.in_valid  = in_valid;
  assign b16.in_data   = in_data;
  assign b16.in_inv    = in_inv;
  assign b16.in_tag    = in_tag;
  assign b16.out_ready = out_ready;

  sbox_array #(.LANES(4),  .TAG_W(4)) u4  (.clk(clk), .rst(rst), .bus(b4));
  sbox_array #(.LANES(1),  .TAG_W(1)) u1  (.clk(clk), .rst(rst), .bus(b1));
  sbox_array #(.LANES(16), .TAG_W(8)) u16 (.clk(clk), .rst(rst), .bus(b16));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r    = 8'h01;
    base = x;
    e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] exp_sub(input logic [127:0] d, input logic inv);
    logic [127:0] e;
    for (int i = 0; i < 16; i++) begin
      e[8*i +: 8] = inv ? ref_inv[d[8*i +: 8]] : ref_fwd[d[8*i +: 8]];
    end
    return e;
  endfunction

  function automatic logic exp_ready();
    return !(q.size() == 2 && !out_ready);
  endfunction

  function automatic logic exp_ovalid();
    if (q.size() == 0) return 1'b0;
    return edges > q[0].acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic model_update();
    logic  er;
    logic  ev;
    beat_t b;
    er = exp_ready();
    ev = exp_ovalid();
    if (ev && out_ready) void'(q.pop_front());
    if (in_valid && er) begin
      b.d   = in_data;
      b.inv = in_inv;
      b.tag = in_tag;
      b.acc = edges + 1;
      q.push_back(b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0;
    in_data = '0; in_tag = '0;
    tick();
    tick();
    checks++;
    if (b4.out_valid !== 1'b0 || b1.out_valid !== 1'b0 || b16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b/%b/%b expected 0", b4.out_valid, b1.out_valid, b16.out_valid);
    end
    checks++;
    if (b4.out_data !== 32'h0 || b1.out_data !== 8'h0 || b16.out_data !== 128'h0 ||
        b4.out_tag !== 4'h0 || b1.out_tag !== 1'b0 || b16.out_tag !== 8'h0) begin
      errors++;
      $display("FAIL reset_out_zero: got data %h tag %h expected 0", b16.out_data, b16.out_tag);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (b4.in_ready !== 1'b1 || b1.in_ready !== 1'b1 || b16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b/%b expected 1", b4.in_ready, b1.in_ready, b16.in_ready);
    end
  endtask

  task automatic test_forward_lanes();
    // forward beat, then an inverse beat, each checked at 1, 2 and 3 cycles
    logic [127:0] din  [2];
    logic [127:0] dexp [2];
    logic [7:0]   tg   [2];
    din[0] = {4{32'hFF530100}}; dexp[0] = {4{32'h16ED7C63}}; tg[0] = 8'h05;
    din[1] = {4{32'h16ED637C}}; dexp[1] = {4{32'hFF530001}}; tg[1] = 8'hA6;
    out_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      in_valid = 1'b1; in_data = din[n]; in_inv = (n == 1); in_tag = tg[n];
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (b4.out_valid !== 1'b0 || b1.out_valid !== 1'b0 || b16.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL lanes%0d_early_valid: got %b expected 0", n, b4.out_valid);
      end
      tick();
      checks++;
      if (b4.out_valid !== 1'b1 || b1.out_valid !== 1'b1 || b16.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL lanes%0d_valid: got %b/%b/%b expected 1", n, b4.out_valid, b1.out_valid, b16.out_valid);
      end
      checks++;
      if (b4.out_data !== dexp[n][31:0] || b1.out_data !== dexp[n][7:0] || b16.out_data !== dexp[n]) begin
        errors++;
        $display("FAIL lanes%0d_data: got %h / %h / %h expected %h", n, b4.out_data, b1.out_data, b16.out_data, dexp[n]);
      end
      checks++;
      if (b4.out_tag !== tg[n][3:0] || b1.out_tag !== tg[n][0] || b16.out_tag !== tg[n]) begin
        errors++;
        $display("FAIL lanes%0d_tag: got %h/%h/%h expected %h", n, b4.out_tag, b1.out_tag, b16.out_tag, tg[n]);
      end
      tick();
      checks++;
      if (b4.out_valid !== 1'b0 || b1.out_valid !== 1'b0 || b16.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL lanes%0d_one_cycle: got %b expected 0", n, b4.out_valid);
      end
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] cap [256];
    logic [127:0] orig;
    logic [127:0] e;
    out_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      in_inv = (pass == 1);
      for (int k = 0; k < 258; k++) begin
        if (k < 256) begin
          in_valid = 1'b1;
          in_tag   = 8'(k);
          for (int i = 0; i < 16; i++) in_data[8*i +: 8] = 8'(k + 17 * i);
          if (pass == 1) in_data = cap[k];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (k >= 2) begin
          for (int i = 0; i < 16; i++) orig[8*i +: 8] = 8'(k - 2 + 17 * i);
          e = (pass == 0) ? exp_sub(orig, 1'b0) : orig;
          checks++;
          if (b4.out_valid !== 1'b1 || b1.out_valid !== 1'b1 || b16.out_valid !== 1'b1 ||
              b4.out_data !== e[31:0] || b1.out_data !== e[7:0] || b16.out_data !== e ||
              b16.out_tag !== 8'(k - 2) || b4.out_tag !== 4'(k - 2) || b1.out_tag !== 1'(k - 2)) begin
            errors++;
            $display("FAIL roundtrip%0d beat %0d: got v=%b data %h tag %h expected data %h tag %h",
                     pass, k - 2, b16.out_valid, b16.out_data, b16.out_tag, e, 8'(k - 2));
          end
          if (pass == 0) cap[k-2] = b16.out_data;
        end
        tick();
      end
    end
  endtask

  task automatic test_backpressure();
    int           next_tag;
    int           outs;
    bit           saw_stall;
    logic         er;
    logic         ev;
    logic [127:0] e;
    q.delete();
    next_tag = 0; outs = 0; saw_stall = 1'b0;
    for (int c = 0; c < 30; c++) begin
      in_valid  = (next_tag < 10);
      in_inv    = 1'b0;
      in_tag    = 8'(next_tag);
      for (int i = 0; i < 16; i++) in_data[8*i +: 8] = 8'(next_tag * 16 + i);
      out_ready = !(c >= 3 && c <= 7);
      #1;
      er = exp_ready();
      ev = exp_ovalid();
      if (b4.in_ready === 1'b0) saw_stall = 1'b1;
      checks++;
      if (b4.in_ready !== er || b1.in_ready !== er || b16.in_ready !== er) begin
        errors++;
        $display("FAIL bp_in_ready c=%0d: got %b/%b/%b expected %b", c, b4.in_ready, b1.in_ready, b16.in_ready, er);
      end
      checks++;
      if (b4.out_valid !== ev || b1.out_valid !== ev || b16.out_valid !== ev) begin
        errors++;
        $display("FAIL bp_out_valid c=%0d: got %b/%b/%b expected %b", c, b4.out_valid, b1.out_valid, b16.out_valid, ev);
      end
      if (ev) begin
        e = exp_sub(q[0].d, q[0].inv);
        checks++;
        if (b4.out_data !== e[31:0] || b1.out_data !== e[7:0] || b16.out_data !== e) begin
          errors++;
          $display("FAIL bp_data c=%0d: got %h expected %h", c, b16.out_data, e);
        end
        checks++;
        if (b16.out_tag !== 8'(outs) || b4.out_tag !== 4'(outs) || b1.out_tag !== 1'(outs)) begin
          errors++;
          $display("FAIL bp_order c=%0d: got tag %0d expected %0d", c, b16.out_tag, outs);
        end
      end
      if (ev && out_ready) outs++;
      if (in_valid && er) next_tag++;
      model_update();
      tick();
    end
    checks++;
    if (outs != 10) begin
      errors++;
      $display("FAIL bp_count: got %0d beats expected 10", outs);
    end
    checks++;
    if (!saw_stall) begin
      errors++;
      $display("FAIL bp_stall: got in_ready never low expected a stall");
    end
  endtask

  task automatic test_simultaneous();
    logic         er;
    logic         ev;
    logic         inv_n;
    logic [127:0] data_n;
    logic [7:0]   tag_n;
    logic [127:0] e;
    q.delete();
    inv_n = 1'b0; tag_n = 8'h00;
    data_n = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 63; c++) begin
      in_valid  = (c < 60);
      in_inv    = inv_n;
      in_data   = data_n;
      in_tag    = tag_n;
      out_ready = (c < 2) ? 1'b0 : ((c >= 60) ? 1'b1 : 1'($urandom_range(0, 1)));
      #1;
      er = exp_ready();
      ev = exp_ovalid();
      checks++;
      if (b4.in_ready !== er || b1.in_ready !== er || b16.in_ready !== er) begin
        errors++;
        $display("FAIL sim_in_ready c=%0d: got %b/%b/%b expected %b", c, b4.in_ready, b1.in_ready, b16.in_ready, er);
      end
      checks++;
      if (b4.out_valid !== ev || b1.out_valid !== ev || b16.out_valid !== ev) begin
        errors++;
        $display("FAIL sim_out_valid c=%0d: got %b expected %b", c, b16.out_valid, ev);
      end
      if (ev) begin
        e = exp_sub(q[0].d, q[0].inv);
        checks++;
        if (b4.out_data !== e[31:0] || b1.out_data !== e[7:0] || b16.out_data !== e ||
            b4.out_tag !== q[0].tag[3:0] || b1.out_tag !== q[0].tag[0] || b16.out_tag !== q[0].tag) begin
          errors++;
          $display("FAIL sim_beat c=%0d: got %h tag %h expected %h tag %h", c, b16.out_data, b16.out_tag, e, q[0].tag);
        end
      end
      if (in_valid && er) begin
        inv_n  = ~inv_n;
        tag_n  = tag_n + 8'h01;
        data_n = {$urandom, $urandom, $urandom, $urandom};
      end
      model_update();
      tick();
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    q.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0;
    in_data = {16{8'h11}}; in_tag = 8'h03;
    tick();
    in_data = {16{8'h22}}; in_tag = 8'h04;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (b4.out_valid !== 1'b1 || b4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full: got valid %b ready %b expected 1 0", b4.out_valid, b4.in_ready);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (b4.out_valid !== 1'b0 || b1.out_valid !== 1'b0 || b16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_out_valid: got %b/%b/%b expected 0", b4.out_valid, b1.out_valid, b16.out_valid);
    end
    checks++;
    if (b4.out_data !== 32'h0 || b1.out_data !== 8'h0 || b16.out_data !== 128'h0 ||
        b4.out_tag !== 4'h0 || b1.out_tag !== 1'b0 || b16.out_tag !== 8'h0) begin
      errors++;
      $display("FAIL mid_out_zero: got data %h tag %h expected 0", b16.out_data, b16.out_tag);
    end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (b4.in_ready !== 1'b1 || b1.in_ready !== 1'b1 || b16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_ready: got %b/%b/%b expected 1", b4.in_ready, b1.in_ready, b16.in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (b4.out_valid !== 1'b0 || b1.out_valid !== 1'b0 || b16.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_ghost c=%0d: got valid %b data %h expected no beat", c, b16.out_valid, b16.out_data);
      end
    end
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      ref_fwd[x] = sbox_model(8'(x));
      ref_inv[ref_fwd[x]] = 8'(x);
    end
    test_reset();
    test_forward_lanes();
    test_round_trip();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
